qtree_ram_loader: RTL and testbench
===================================

# qtree_ram_loader

Write-side loader for the quadtree lookup pipeline's per-level node RAMs. Accepts single-key host writes over a valid/ready port and assembles each node's three keys (l, m, r) into one RAM word. Drives the broadcast RAM write port shared by all search levels. After reset, or on command, fills every node of every level with all-ones keys so unloaded branches never match early.

## Interface
Parameters:
- LEVEL_CNT, 4: number of search levels; level i holds 4^i nodes.
- KEY_WIDTH, 16: key width.
- NODE_WIDTH, 2*(LEVEL_CNT-1) (min 1): broadcast node address width. Level i uses the low max(1, 2*i) bits.
- RAM_DATA_WIDTH, 3*KEY_WIDTH: node word, {l, m, r} with l in the MSBs.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- wr_valid_i  in  1  host key write valid
- wr_ready_o  out  1  high only in IDLE
- wr_level_i  in  $clog2(LEVEL_CNT) (min 1)  target level
- wr_node_i  in  NODE_WIDTH  node index within level
- wr_slot_i  in  2  0=l, 1=m, 2=r (commit), 3=reserved
- wr_key_i  in  KEY_WIDTH  key value
- init_start_i  in  1  start fill, sampled in IDLE
- busy_o  out  1  fill in progress
- err_o  out  1  one-cycle pulse on a dropped illegal write
- mm_ram_data_o  out  RAM_DATA_WIDTH  broadcast write data
- mm_ram_addr_o  out  NODE_WIDTH  broadcast write address
- mm_ram_write_o  out  LEVEL_CNT  per-level write strobe

## Operation
- Two states, INIT and IDLE.
- Reset puts the block in INIT, clears the fill counter to 0, and sets shadow l and m to all-ones.
- Output values while rst_i is high:
  - mm_ram_write_o = 0, err_o = 0, mm_ram_data_o = 0, mm_ram_addr_o = 0.
  - busy_o = 1, wr_ready_o = 0.
- INIT fill:
  - Each cycle, present counter c on mm_ram_addr_o with data all-ones.
  - Assert mm_ram_write_o[i] for every level i with c < 4^i. All levels are written in parallel.
  - Increment c. After c = 4^(LEVEL_CNT-1)-1, go to IDLE.
  - Shadow registers are reset to all-ones on entry.
- IDLE, accept when wr_valid_i && wr_ready_o:
  - slot 0: store the key in shadow l.
  - slot 1: store the key in shadow m.
  - slot 2: commit. Drive {shadow l, shadow m, wr_key_i} to node wr_node_i and strobe only bit wr_level_i. Then reset shadow l and m to all-ones.
  - slot 3, wr_level_i >= LEVEL_CNT, or wr_node_i >= 4^wr_level_i: drop the write, leave shadow unchanged, pulse err_o.
- The shadow is a single staging register, not per node. The host must write l, m, r of one node in order. An r write with a stale shadow commits all-ones for the missing keys.
- init_start_i in IDLE enters INIT. If a write is accepted in the same cycle, that write is dropped silently (no err_o) and the shadow is reset.
- init_start_i in INIT is ignored; the fill does not restart.
- rst_i high mid-fill or mid-node restarts the fill from c = 0 and discards the shadow.

## Timing
- All outputs are registered.
- Commit accepted at cycle N: RAM strobe, data and address valid at N+1, for exactly one cycle.
- err_o rises at N+1 for an illegal write accepted at N.
- Fill after reset:
  - First strobe on the first cycle after rst_i falls.
  - The fill lasts 4^(LEVEL_CNT-1) cycles; 64 for LEVEL_CNT=4.
  - busy_o is high through the last strobe cycle.
  - wr_ready_o rises on the cycle after the last strobe.
- Commanded fill: init_start_i at N gives busy_o=1 and first strobe at N+1, and wr_ready_o=0 from N+1.
- Throughput: one key per cycle in IDLE; a full node takes 3 cycles.
- Strobes from host commits and from the fill never overlap.

## Structure
- Shared package holds:
  - level_ram_data_t, the packed struct {l, m, r}, shared with the search levels.
  - The slot enum (SLOT_L, SLOT_M, SLOT_R).
  - A constant function level_nodes(i) = 4^i.
- No sub-module. The level-range and node-range check is a combinational function in the package.

## Test plan
- Reset fill, LEVEL_CNT=4: release reset. Expect 64 strobe cycles, addresses 0..63, data 48'hFFFF_FFFF_FFFF. Expect strobes 4'b1111 at c=0, 4'b1110 at c=1..3, 4'b1100 at c=4..15, 4'b1000 at c=16..63. Then busy_o=0 and wr_ready_o=1.
- Node write: level 2, node 5, keys 16'h0010, 16'h0020, 16'h0030 on consecutive cycles. Expect one cycle with mm_ram_write_o=4'b0100, addr=5, data=48'h0010_0020_0030, one cycle after the r write.
- Partial node: r-only write of 16'h0007 to level 1, node 3. Expect data 48'hFFFF_FFFF_0007, strobe 4'b0010.
- Illegal writes: slot 3, then level 1 node 4, then level 4. Expect three err_o pulses, no strobes, shadow intact; a following r write commits the earlier l/m.
- Collision: init_start_i together with an accepted slot 2 write in IDLE. Expect no commit strobe, no err_o, busy_o=1 next cycle, and a full 64-cycle fill.
- Reset mid-fill: assert rst_i at c=20. Expect strobes low while rst_i is high, and the fill restarting at addr 0 after release.

Source files
------------

// File: rtl/qtree_ram_loader_pkg.sv
// Shared types and helpers for the quadtree node-RAM loader and the search
// levels that read the RAMs it fills.
package qtree_ram_loader_pkg;

  localparam int unsigned PKG_KEY_WIDTH = 16;

  // One node word as stored in every level RAM: l in the MSBs, r in the LSBs.
  typedef struct packed {
    logic [PKG_KEY_WIDTH-1:0] l;
    logic [PKG_KEY_WIDTH-1:0] m;
    logic [PKG_KEY_WIDTH-1:0] r;
  } level_ram_data_t;

  // Host write slot selector; SLOT_R commits the staged node.
  typedef enum logic [1:0] {
    SLOT_L    = 2'd0,
    SLOT_M    = 2'd1,
    SLOT_R    = 2'd2,
    SLOT_RSVD = 2'd3
  } slot_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Number of nodes held by level lvl (4^lvl).
  function automatic int unsigned level_nodes(input int unsigned lvl);
    return 32'd1 << (32'd2 * lvl);
  endfunction

  // A host write is legal when the slot is not reserved, the level exists,
  // and the node index fits inside that level.
  function automatic logic wr_legal(input logic [1:0]  slot,
                                    input int unsigned level,
                                    input int unsigned node,
                                    input int unsigned level_cnt);
    logic ok;
    ok = 1'b1;
    if (slot == SLOT_RSVD) begin
      ok = 1'b0;
    end else if (level >= level_cnt) begin
      ok = 1'b0;
    end else if (node >= level_nodes(level)) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/qtree_ram_loader.sv
// Write-side loader for the per-level quadtree node RAMs. Stages l/m keys from
// single-key host writes, commits a full node word on the r write, and fills
// every node of every level with all-ones after reset or on command.
module qtree_ram_loader
  import qtree_ram_loader_pkg::*;
#(
  parameter int LEVEL_CNT      = 4,
  parameter int KEY_WIDTH      = 16,
  parameter int NODE_WIDTH     = (LEVEL_CNT > 1) ? 2 * (LEVEL_CNT - 1) : 1,
  parameter int RAM_DATA_WIDTH = 3 * KEY_WIDTH,
  parameter int LVL_WIDTH      = (LEVEL_CNT > 1) ? $clog2(LEVEL_CNT) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [LVL_WIDTH-1:0]      wr_level_i,
  input  logic [NODE_WIDTH-1:0]     wr_node_i,
  input  logic [1:0]                wr_slot_i,
  input  logic [KEY_WIDTH-1:0]      wr_key_i,
  input  logic                      init_start_i,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [RAM_DATA_WIDTH-1:0] mm_ram_data_o,
  output logic [NODE_WIDTH-1:0]     mm_ram_addr_o,
  output logic [LEVEL_CNT-1:0]      mm_ram_write_o
);

  // Last fill address: the deepest level has 4^(LEVEL_CNT-1) nodes.
  localparam logic [NODE_WIDTH-1:0] FILL_LAST =
    NODE_WIDTH'(level_nodes(LEVEL_CNT - 1) - 32'd1);

  state_e                    state_q, state_d;
  logic [NODE_WIDTH-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]      shad_l_q, shad_l_d;
  logic [KEY_WIDTH-1:0]      shad_m_q, shad_m_d;
  logic [LEVEL_CNT-1:0]      write_q, write_d;
  logic [NODE_WIDTH-1:0]     addr_q, addr_d;
  logic [RAM_DATA_WIDTH-1:0] data_q, data_d;
  logic                      err_q, err_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;

  logic                      fill_s;
  logic [NODE_WIDTH-1:0]     fill_c_s;

  // Next-state, staging and output-word decode; a fill step wins over any host write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shad_l_d = shad_l_q;
    shad_m_d = shad_m_q;
    write_d  = '0;
    addr_d   = '0;
    data_d   = '0;
    err_d    = 1'b0;

    // A commanded fill issues its c=0 step in the same cycle it is seen, so
    // the first strobe lands one cycle after init_start_i.
    fill_s   = (state_q == ST_INIT) || init_start_i;
    fill_c_s = (state_q == ST_INIT) ? cnt_q : '0;

    if (fill_s) begin
      for (int i = 0; i < LEVEL_CNT; i++) begin
        write_d[i] = (32'(fill_c_s) < level_nodes(i));
      end
      addr_d   = fill_c_s;
      data_d   = {RAM_DATA_WIDTH{1'b1}};
      shad_l_d = {KEY_WIDTH{1'b1}};
      shad_m_d = {KEY_WIDTH{1'b1}};
      if (fill_c_s == FILL_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_INIT;
        cnt_d   = fill_c_s + NODE_WIDTH'(1);
      end
    end else if (wr_valid_i && ready_q) begin
      if (!wr_legal(wr_slot_i, 32'(wr_level_i), 32'(wr_node_i), LEVEL_CNT)) begin
        err_d = 1'b1;
      end else begin
        case (slot_e'(wr_slot_i))
          SLOT_L: shad_l_d = wr_key_i;
          SLOT_M: shad_m_d = wr_key_i;
          SLOT_R: begin
            data_d              = {shad_l_q, shad_m_q, wr_key_i};
            addr_d              = wr_node_i;
            write_d[wr_level_i] = 1'b1;
            shad_l_d            = {KEY_WIDTH{1'b1}};
            shad_m_d            = {KEY_WIDTH{1'b1}};
          end
          default: err_d = 1'b1;
        endcase
      end
    end else begin
      state_d = state_q;
    end

    // busy stays up through the last fill strobe; ready returns one cycle later.
    busy_d  = (state_q == ST_INIT) || (state_d == ST_INIT);
    ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
  end

  // State, staging and registered output port update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      shad_l_q <= {KEY_WIDTH{1'b1}};
      shad_m_q <= {KEY_WIDTH{1'b1}};
      write_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shad_l_q <= shad_l_d;
      shad_m_q <= shad_m_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign wr_ready_o     = ready_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;
  assign mm_ram_data_o  = data_q;
  assign mm_ram_addr_o  = addr_q;
  assign mm_ram_write_o = write_q;

endmodule

// File: tb/tb_qtree_ram_loader.sv
// Directed self-checking bench for qtree_ram_loader (LEVEL_CNT=4, KEY_WIDTH=16).
module tb_qtree_ram_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [1:0]  wr_level_i;
  logic [5:0]  wr_node_i;
  logic [1:0]  wr_slot_i;
  logic [15:0] wr_key_i;
  logic        init_start_i;
  logic        busy_o;
  logic        err_o;
  logic [47:0] mm_ram_data_o;
  logic [5:0]  mm_ram_addr_o;
  logic [3:0]  mm_ram_write_o;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] ONES48 = 48'hFFFF_FFFF_FFFF;

  qtree_ram_loader dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_level_i    (wr_level_i),
    .wr_node_i     (wr_node_i),
    .wr_slot_i     (wr_slot_i),
    .wr_key_i      (wr_key_i),
    .init_start_i  (init_start_i),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .mm_ram_data_o (mm_ram_data_o),
    .mm_ram_addr_o (mm_ram_addr_o),
    .mm_ram_write_o(mm_ram_write_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] lvl, input logic [5:0] node,
                         input logic [1:0] slot, input logic [15:0] key);
    wr_valid_i = 1'b1;
    wr_level_i = lvl;
    wr_node_i  = node;
    wr_slot_i  = slot;
    wr_key_i   = key;
    tick();
    wr_valid_i = 1'b0;
  endtask

  // Expected fill strobe at address c, from the level sizes 1, 4, 16, 64.
  function automatic logic [3:0] fill_strobe(input int c);
    if (c == 0)       return 4'b1111;
    else if (c < 4)   return 4'b1110;
    else if (c < 16)  return 4'b1100;
    else              return 4'b1000;
  endfunction

  // Walk a full 64-cycle fill starting at the cycle showing c=0; optionally
  // pokes init_start_i mid-fill, which must be ignored.
  task automatic fill_check(input string tag, input bit poke);
    for (int c = 0; c < 64; c++) begin
      check({tag, "_strobe"}, 64'(mm_ram_write_o), 64'(fill_strobe(c)));
      check({tag, "_addr"},   64'(mm_ram_addr_o),  64'(c));
      check({tag, "_data"},   64'(mm_ram_data_o),  64'(ONES48));
      check({tag, "_busy"},   64'(busy_o),         64'(1'b1));
      check({tag, "_ready"},  64'(wr_ready_o),     64'(1'b0));
      init_start_i = poke && (c == 10);
      tick();
    end
    init_start_i = 1'b0;
    check({tag, "_end_strobe"}, 64'(mm_ram_write_o), 64'(4'b0000));
    check({tag, "_end_busy"},   64'(busy_o),         64'(1'b0));
    check({tag, "_end_ready"},  64'(wr_ready_o),     64'(1'b1));
  endtask

  initial begin
    rst_i        = 1'b1;
    wr_valid_i   = 1'b0;
    wr_level_i   = 2'd0;
    wr_node_i    = 6'd0;
    wr_slot_i    = 2'd0;
    wr_key_i     = 16'd0;
    init_start_i = 1'b0;
    tick();
    tick();
    tick();

    // Reset state
    check("rst_strobe", 64'(mm_ram_write_o), 64'(4'b0000));
    check("rst_err",    64'(err_o),          64'(1'b0));
    check("rst_data",   64'(mm_ram_data_o),  64'(48'd0));
    check("rst_addr",   64'(mm_ram_addr_o),  64'(6'd0));
    check("rst_busy",   64'(busy_o),         64'(1'b1));
    check("rst_ready",  64'(wr_ready_o),     64'(1'b0));

    // Fill after reset release: first strobe one cycle after rst_i falls
    rst_i = 1'b0;
    tick();
    fill_check("rstfill", 1'b0);

    // Full node write to level 2, node 5
    host_wr(2'd2, 6'd5, 2'd0, 16'h0010);
    check("node_l_nostrobe", 64'(mm_ram_write_o), 64'(4'b0000));
    host_wr(2'd2, 6'd5, 2'd1, 16'h0020);
    host_wr(2'd2, 6'd5, 2'd2, 16'h0030);
    check("node_strobe", 64'(mm_ram_write_o), 64'(4'b0100));
    check("node_addr",   64'(mm_ram_addr_o),  64'(6'd5));
    check("node_data",   64'(mm_ram_data_o),  64'(48'h0010_0020_0030));
    check("node_err",    64'(err_o),          64'(1'b0));
    tick();
    check("node_one_cycle", 64'(mm_ram_write_o), 64'(4'b0000));

    // r-only write: shadow was reset by the previous commit
    host_wr(2'd1, 6'd3, 2'd2, 16'h0007);
    check("part_strobe", 64'(mm_ram_write_o), 64'(4'b0010));
    check("part_addr",   64'(mm_ram_addr_o),  64'(6'd3));
    check("part_data",   64'(mm_ram_data_o),  64'(48'hFFFF_FFFF_0007));
    tick();
    check("part_one_cycle", 64'(mm_ram_write_o), 64'(4'b0000));

    // Illegal writes between staging and commit must not disturb the shadow
    host_wr(2'd3, 6'd0, 2'd0, 16'h00AA);
    check("stage_l_err", 64'(err_o), 64'(1'b0));
    host_wr(2'd3, 6'd0, 2'd1, 16'h00BB);
    host_wr(2'd0, 6'd0, 2'd3, 16'h1111);
    check("ill_slot_err",    64'(err_o),          64'(1'b1));
    check("ill_slot_strobe", 64'(mm_ram_write_o), 64'(4'b0000));
    host_wr(2'd1, 6'd4, 2'd0, 16'h2222);
    check("ill_node_err",    64'(err_o),          64'(1'b1));
    check("ill_node_strobe", 64'(mm_ram_write_o), 64'(4'b0000));
    // The 2-bit level port cannot encode level 4; level 0 node 1 is out of range instead.
    host_wr(2'd0, 6'd1, 2'd1, 16'h3333);
    check("ill_lvl0_err",    64'(err_o),          64'(1'b1));
    check("ill_lvl0_strobe", 64'(mm_ram_write_o), 64'(4'b0000));
    host_wr(2'd3, 6'd63, 2'd2, 16'h00CC);
    check("after_ill_err",    64'(err_o),          64'(1'b0));
    check("after_ill_strobe", 64'(mm_ram_write_o), 64'(4'b1000));
    check("after_ill_addr",   64'(mm_ram_addr_o),  64'(6'd63));
    check("after_ill_data",   64'(mm_ram_data_o),  64'(48'h00AA_00BB_00CC));
    tick();

    // Collision: stage an l key, then init_start_i with an accepted r write
    host_wr(2'd0, 6'd0, 2'd0, 16'h1234);
    init_start_i = 1'b1;
    host_wr(2'd0, 6'd0, 2'd2, 16'h0055);
    init_start_i = 1'b0;
    check("coll_err", 64'(err_o), 64'(1'b0));
    fill_check("collfill", 1'b1);

    // Shadow was discarded by the fill: r-only commit shows all-ones l/m
    host_wr(2'd0, 6'd0, 2'd2, 16'h0001);
    check("post_fill_strobe", 64'(mm_ram_write_o), 64'(4'b0001));
    check("post_fill_data",   64'(mm_ram_data_o),  64'(48'hFFFF_FFFF_0001));
    tick();

    // Reset mid-fill at c=20
    init_start_i = 1'b1;
    tick();
    init_start_i = 1'b0;
    check("mid_first_addr", 64'(mm_ram_addr_o), 64'(6'd0));
    for (int k = 0; k < 20; k++) tick();
    check("mid_addr20", 64'(mm_ram_addr_o), 64'(6'd20));
    rst_i = 1'b1;
    tick();
    check("mid_rst_strobe1", 64'(mm_ram_write_o), 64'(4'b0000));
    check("mid_rst_busy",    64'(busy_o),         64'(1'b1));
    check("mid_rst_ready",   64'(wr_ready_o),     64'(1'b0));
    tick();
    check("mid_rst_strobe2", 64'(mm_ram_write_o), 64'(4'b0000));
    rst_i = 1'b0;
    tick();
    fill_check("refill", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
